// File: rtl/regfile_param_sync.sv
// Parametrised register file: one synchronous write port, two registered read ports
// with valid strobes, and a bulk-clear sequencer. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_param_sync #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] WriteAddress,
  input  logic [DATA_WIDTH-1:0] WriteValue,
  input  logic                  ReadEnable1,
  input  logic [ADDR_WIDTH-1:0] ReadAddress1,
  input  logic                  ReadEnable2,
  input  logic [ADDR_WIDTH-1:0] ReadAddress2,
  output logic [DATA_WIDTH-1:0] ReadValue1,
  output logic [DATA_WIDTH-1:0] ReadValue2,
  output logic                  ReadValid1,
  output logic                  ReadValid2,
  input  logic                  ClearReq,
  output logic                  Busy
);

  localparam int unsigned           DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clear_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  write_ok;
  logic                  read_ok1;
  logic                  read_ok2;
  logic [DATA_WIDTH-1:0] rd_data1;
  logic [DATA_WIDTH-1:0] rd_data2;

  assign Busy     = (state == CLEAR);
  assign write_ok = WriteEnable && !Busy && !(ZERO_REG && (WriteAddress == '0));
  assign read_ok1 = ReadEnable1 && !Busy;
  assign read_ok2 = ReadEnable2 && !Busy;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ClearReq) state_next = CLEAR;
      CLEAR:   if (clear_cnt == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter is parked at zero in IDLE so CLEAR always starts from entry 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clear_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clear_cnt <= clear_cnt + 1'b1;
      else                clear_cnt <= '0;
    end
  end

  // Zero-register forcing is applied last so it also overrides the bypass path.
  always_comb begin
    rd_data1 = mem[ReadAddress1];
    if (BYPASS && write_ok && (WriteAddress == ReadAddress1)) rd_data1 = WriteValue;
    if (ZERO_REG && (ReadAddress1 == '0)) rd_data1 = '0;
  end

  always_comb begin
    rd_data2 = mem[ReadAddress2];
    if (BYPASS && write_ok && (WriteAddress == ReadAddress2)) rd_data2 = WriteValue;
    if (ZERO_REG && (ReadAddress2 == '0)) rd_data2 = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (Busy) begin
      mem[clear_cnt] <= '0;
    end else if (write_ok) begin
      mem[WriteAddress] <= WriteValue;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReadValue1 <= '0;
      ReadValue2 <= '0;
      ReadValid1 <= 1'b0;
      ReadValid2 <= 1'b0;
    end else begin
      ReadValid1 <= read_ok1;
      ReadValid2 <= read_ok2;
      if (read_ok1) ReadValue1 <= rd_data1;
      if (read_ok2) ReadValue2 <= rd_data2;
    end
  end

endmodule

// File: tb/tb_regfile_param_sync.sv
// Bench for regfile_param_sync: directed and random accesses checked against an
// array model, bulk clear timing, reset during clear, and a narrow 8x8 instance.
module tb_regfile_param_sync;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        we, re1, re2, clr;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] wv, rv1, rv2;
  logic        vld1, vld2, busy;

  logic        s_we, s_re1, s_re2, s_clr;
  logic [2:0]  s_wa, s_ra1, s_ra2;
  logic [7:0]  s_wv, s_rv1, s_rv2;
  logic        s_vld1, s_vld2, s_busy;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [32];
  logic [31:0] exp_rv1, exp_rv2;

  always #5 clk = ~clk;

  regfile_param_sync dut (
    .clk(clk), .reset(reset),
    .WriteEnable(we), .WriteAddress(wa), .WriteValue(wv),
    .ReadEnable1(re1), .ReadAddress1(ra1), .ReadEnable2(re2), .ReadAddress2(ra2),
    .ReadValue1(rv1), .ReadValue2(rv2), .ReadValid1(vld1), .ReadValid2(vld2),
    .ClearReq(clr), .Busy(busy)
  );

  regfile_param_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1'b1)) dut_small (
    .clk(clk), .reset(reset),
    .WriteEnable(s_we), .WriteAddress(s_wa), .WriteValue(s_wv),
    .ReadEnable1(s_re1), .ReadAddress1(s_ra1), .ReadEnable2(s_re2), .ReadAddress2(s_ra2),
    .ReadValue1(s_rv1), .ReadValue2(s_rv2), .ReadValid1(s_vld1), .ReadValid2(s_vld2),
    .ClearReq(s_clr), .Busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = '0; wv = '0; re1 = 1'b0; ra1 = '0; re2 = 1'b0; ra2 = '0; clr = 1'b0;
  endtask

  function automatic logic [31:0] expect_read(input logic [4:0] a, input logic wr);
    if (a == 5'd0) return 32'h0;
    if (BYP && wr && (wa == a)) return wv;
    return model[a];
  endfunction

  // One non-busy edge: predict from the model, clock, compare, then commit the write.
  task automatic step(input string tag);
    logic wr;
    wr = we && (wa != 5'd0);
    if (re1) exp_rv1 = expect_read(ra1, wr);
    if (re2) exp_rv2 = expect_read(ra2, wr);
    cycle();
    if (wr) model[wa] = wv;
    chk({tag, "_vld1"}, {31'b0, vld1}, {31'b0, re1});
    chk({tag, "_vld2"}, {31'b0, vld2}, {31'b0, re2});
    chk({tag, "_rv1"}, rv1, exp_rv1);
    chk({tag, "_rv2"}, rv2, exp_rv2);
  endtask

  initial begin
    int cnt;
    int n;
    reset = 1'b1;
    idle_inputs();
    s_we = 1'b0; s_wa = '0; s_wv = '0; s_re1 = 1'b0; s_ra1 = '0;
    s_re2 = 1'b0; s_ra2 = '0; s_clr = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    exp_rv1 = 32'h0; exp_rv2 = 32'h0;
    cycle(); cycle();
    chk("rst_rv1", rv1, 32'h0);
    chk("rst_vld1", {31'b0, vld1}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;

    for (int a = 0; a < 32; a++) begin
      re1 = 1'b1; ra1 = 5'(a); re2 = 1'b1; ra2 = 5'(31 - a);
      step("rd_reset");
    end
    idle_inputs();
    step("rd_idle");

    we = 1'b1; wa = 5'd7; wv = 32'hDEADBEEF; step("wr7");
    idle_inputs(); re1 = 1'b1; ra1 = 5'd7; re2 = 1'b1; ra2 = 5'd7; step("rd7");
    chk("rd7_lit", rv2, 32'hDEADBEEF);
    idle_inputs(); we = 1'b1; wa = 5'd0; wv = 32'h12345678; step("wr0");
    idle_inputs(); re1 = 1'b1; ra1 = 5'd0; step("rd0");
    chk("rd0_lit", rv1, 32'h0);

    idle_inputs(); we = 1'b1; wa = 5'd3; wv = 32'h1; step("wr3");
    we = 1'b1; wa = 5'd3; wv = 32'hA5A5A5A5; re1 = 1'b1; ra1 = 5'd3; step("rw3");
    chk("rw3_lit", rv1, BYP ? 32'hA5A5A5A5 : 32'h00000001);
    idle_inputs(); re2 = 1'b1; ra2 = 5'd3; step("rd3");
    chk("rd3_lit", rv2, 32'hA5A5A5A5);

    for (int k = 0; k < 300; k++) begin
      we  = 1'($urandom);
      wa  = 5'($urandom);
      wv  = $urandom;
      re1 = 1'($urandom);
      re2 = 1'($urandom);
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      step("rand");
    end

    idle_inputs();
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; wa = 5'(a); wv = $urandom | 32'h1; step("fill");
    end
    we = 1'b1; wa = 5'd5; wv = 32'hCAFEF00D; re1 = 1'b1; ra1 = 5'd5; clr = 1'b1;
    step("clr_edge");
    chk("busy_rise", {31'b0, busy}, 32'h1);
    cnt = 1; n = 0;
    while (busy && n < 100) begin
      we = 1'b1; wa = 5'($urandom); wv = $urandom; re1 = 1'b1; ra1 = 5'($urandom);
      re2 = 1'b1; ra2 = 5'($urandom); clr = 1'($urandom);
      cycle();
      n++;
      chk("busy_vld1", {31'b0, vld1}, 32'h0);
      chk("busy_vld2", {31'b0, vld2}, 32'h0);
      chk("busy_hold1", rv1, exp_rv1);
      if (busy) cnt++;
    end
    chk("busy_cycles", 32'(cnt), 32'd32);
    idle_inputs();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int a = 0; a < 32; a++) begin
      re1 = 1'b1; ra1 = 5'(a); re2 = 1'b1; ra2 = 5'(a); step("rd_clr");
    end

    idle_inputs();
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; wa = 5'(a); wv = 32'h100 + 32'(a); step("fill2");
    end
    idle_inputs(); clr = 1'b1; cycle(); clr = 1'b0;
    repeat (9) cycle();
    chk("clr10_busy", {31'b0, busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rstclr_busy", {31'b0, busy}, 32'h0);
    chk("rstclr_rv2", rv2, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    exp_rv1 = 32'h0; exp_rv2 = 32'h0;
    we = 1'b1; wa = 5'd31; wv = 32'h55; step("wr31");
    chk("wr31_busy", {31'b0, busy}, 32'h0);
    idle_inputs(); re1 = 1'b1; ra1 = 5'd31; re2 = 1'b1; ra2 = 5'd9; step("rd31");
    chk("rd31_lit", rv1, 32'h55);
    idle_inputs();

    s_we = 1'b1; s_wa = 3'd7; s_wv = 8'hFF; cycle();
    s_we = 1'b0; s_re1 = 1'b1; s_ra1 = 3'd7; s_re2 = 1'b1; s_ra2 = 3'd0; cycle();
    chk("s_rd7", {24'b0, s_rv1}, 32'hFF);
    chk("s_rd0", {24'b0, s_rv2}, 32'h0);
    chk("s_vld1", {31'b0, s_vld1}, 32'h1);
    s_re1 = 1'b0; s_re2 = 1'b0; s_clr = 1'b1; cycle(); s_clr = 1'b0;
    cnt = 0; n = 0;
    while (s_busy && n < 50) begin
      cnt++; n++; cycle();
    end
    chk("s_busy_cycles", 32'(cnt), 32'd8);
    s_re1 = 1'b1; s_ra1 = 3'd7; cycle();
    chk("s_rd7_clr", {24'b0, s_rv1}, 32'h0);
    chk("s_vld_clr", {31'b0, s_vld1}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_param_sync.md
# regfile_param_sync

Parametrised, clocked multi-port register file: one synchronous write port, two registered read ports with valid strobes, and a hardware bulk-clear sequencer. Generalises the team's combinational 32×32 register file into a synthesizable storage block with explicit write enable, fixed one-cycle read latency and a zero register. Sits between the decode stage (addresses and enables) and the ALU operand latches of the datapath.

## Interface
- DATA_WIDTH, 32, bits per register
- ADDR_WIDTH, 5, address bits; depth DEPTH = 2**ADDR_WIDTH (derived, not overridable)
- ZERO_REG, 1, when 1, entry 0 always reads 0 and writes to it are discarded

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- WriteEnable  input  1  write request this cycle
- WriteAddress  input  ADDR_WIDTH  write target
- WriteValue  input  DATA_WIDTH  write data
- ReadEnable1, ReadEnable2  input  1  read request, port 1 / port 2
- ReadAddress1, ReadAddress2  input  ADDR_WIDTH  read source
- ReadValue1, ReadValue2  output  DATA_WIDTH  registered read data
- ReadValid1, ReadValid2  output  1  one-cycle pulse: ReadValueN updated
- ClearReq  input  1  request bulk clear of all entries
- Busy  output  1  clear sequencer active; all accesses ignored

## Operation
- Reset (async, any state): all entries 0, ReadValue1/2 = 0, ReadValid1/2 = 0, Busy = 0, FSM = IDLE, clear counter = 0.
- Write: on a clk edge with WriteEnable=1 and Busy=0, entry[WriteAddress] <= WriteValue. Dropped when Busy=1. Dropped when ZERO_REG=1 and WriteAddress=0.
- Read port N: on a clk edge with ReadEnableN=1 and Busy=0, ReadValueN <= entry[ReadAddressN] and ReadValidN <= 1. Otherwise ReadValidN <= 0 and ReadValueN holds its value.
- Address 0 with ZERO_REG=1 always returns 0, bypass included.
- Both ports may read the same address in the same cycle. Each port is independent.
- FSM states:
  - IDLE: Busy=0. ClearReq=1 moves to CLEAR with counter <= 0. Other port activity on that edge is still performed.
  - CLEAR: Busy=1. Each cycle entry[counter] <= 0 and counter increments. When counter = DEPTH-1, that entry is cleared and the FSM returns to IDLE.
  - ClearReq is ignored while in CLEAR.
- Reset during CLEAR: the FSM aborts to IDLE. All entries are 0 by virtue of reset.

## Timing
- Write-to-storage: 1 edge. The write is visible to a read issued on the next cycle.
- Read latency: 1 cycle. Address is sampled at edge k; ReadValueN/ReadValidN are valid after edge k.
- Same-cycle read and write to the same address: behaviour set by configuration (below).
- Clear: Busy rises after the edge that samples ClearReq and stays high for exactly DEPTH cycles. The first access accepted is on the edge at which Busy is sampled 0.
- Busy is the only back-pressure. There is no queuing; requesters must hold or retry.

## Configuration
- REGFILE_BYPASS_EN defined: on a same-edge write and read to the same nonzero address (WriteEnable=1, Busy=0), ReadValueN <= WriteValue (new data).
- Not defined: ReadValueN <= the pre-write entry contents (old data). The new value is visible from the next read.

## Test plan
- Reset with all inputs 0, then read addresses 0..31 on both ports → every ReadValue = 0x00000000, with ReadValid pulsing 1 cycle after each request.
- Write 0xDEADBEEF to 7, then read 7 on port 1 and 7 on port 2 next cycle → both return 0xDEADBEEF. Write 0x12345678 to 0 with ZERO_REG=1, then read 0 → 0x00000000.
- Same-cycle write 0xA5A5A5A5 to 3 (previous value 0x1) with read of 3 → 0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x00000001 without it.
- Fill all entries, pulse ClearReq → Busy high for exactly 32 cycles. Writes/reads during Busy are dropped and ReadValid stays 0. Afterwards all entries read 0.
- Assert reset at cycle 10 of a clear, then write 0x55 to 31 after release → Busy=0 immediately, the write is accepted, and a read of 31 returns 0x55.
- DATA_WIDTH=8, ADDR_WIDTH=3: write 0xFF to 7, read 7 → 0xFF. Clear → Busy for 8 cycles.
